// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with fill count, almost-full/almost-empty flags,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module param_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_req,
    input  logic [DATA_W-1:0]          write_data,
    output logic                       FULL,
    output logic                       AFULL,
    input  logic                       read_req,
    output logic [DATA_W-1:0]          read_data,
    output logic                       rd_valid,
    output logic                       EMP,
    output logic                       AEMP,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, emp_q, afull_q, aemp_q;
    logic              ovf_q, unf_q, rd_valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_ok, rd_ok;

    // Acceptance uses the registered flags from the start of the cycle.
    assign wr_ok = write_req && !full_q;
    assign rd_ok = read_req && !emp_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) wptr_d = wptr_q + AW'(1);
        if (rd_ok) rptr_d = rptr_q + AW'(1);
        if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[wptr_q] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            emp_q   <= 1'b1;
            afull_q <= 1'b0;
            aemp_q  <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            emp_q   <= (count_d == '0);
            afull_q <= (count_d >= AF_C);
            aemp_q  <= (count_d <= AE_C);
            // A new error event in the same cycle as clr_err keeps the flag set.
            ovf_q   <= (ovf_q && !clr_err) || (write_req && full_q);
            unf_q   <= (unf_q && !clr_err) || (read_req && emp_q);
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q    <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rdata_q <= mem[rptr_q];
                end
            end
        end else begin : g_fwft
            // Prefetch the head word; bypass the write port when the head slot is
            // being written this cycle (it is not in the array yet).
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q    <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= (count_d != '0);
                    if (wr_ok && (rptr_d == wptr_q)) rdata_q <= write_data;
                    else if (count_d != '0)          rdata_q <= mem[rptr_d];
                end
            end
        end
    endgenerate

    assign FULL      = full_q;
    assign EMP       = emp_q;
    assign AFULL     = afull_q;
    assign AEMP      = aemp_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign read_data = rdata_q;
    assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a registered-read and a FWFT instance share one stimulus
// stream and are checked against a queue-based reference model and vector tables.
module tb_param_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_req = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       read_req = 1'b0;
    logic       clr_err = 1'b0;

    logic       full0, afull0, rv0, emp0, aemp0, ov0, un0;
    logic [7:0] rdata0;
    logic [4:0] cnt0;
    logic       full1, afull1, rv1, emp1, aemp1, ov1, un1;
    logic [7:0] rdata1;
    logic [4:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .write_req(write_req), .write_data(write_data),
        .FULL(full0), .AFULL(afull0), .read_req(read_req), .read_data(rdata0),
        .rd_valid(rv0), .EMP(emp0), .AEMP(aemp0), .count(cnt0),
        .overflow(ov0), .underflow(un0), .clr_err(clr_err)
    );

    param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .write_req(write_req), .write_data(write_data),
        .FULL(full1), .AFULL(afull1), .read_req(read_req), .read_data(rdata1),
        .rd_valid(rv1), .EMP(emp1), .AEMP(aemp1), .count(cnt1),
        .overflow(ov1), .underflow(un1), .clr_err(clr_err)
    );

    // Reference model: a plain queue plus the sticky flags and registered read output.
    byte unsigned q[$];
    bit           m_ov, m_un, m_rv0;
    bit [7:0]     m_rd0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        check("count",     int'(cnt0),   sz);
        check("FULL",      int'(full0),  int'(sz == 16));
        check("EMP",       int'(emp0),   int'(sz == 0));
        check("AFULL",     int'(afull0), int'(sz >= 14));
        check("AEMP",      int'(aemp0),  int'(sz <= 2));
        check("overflow",  int'(ov0),    int'(m_ov));
        check("underflow", int'(un0),    int'(m_un));
        check("rd_valid",  int'(rv0),    int'(m_rv0));
        check("read_data", int'(rdata0), int'(m_rd0));
        check("fwft_count",    int'(cnt1), sz);
        check("fwft_rd_valid", int'(rv1),  int'(sz != 0));
        if (sz != 0) check("fwft_read_data", int'(rdata1), int'(q[0]));
    endtask

    task automatic step(bit rst, bit wr, bit [7:0] wd, bit rd, bit clr);
        bit was_full, was_emp;
        reset = rst; write_req = wr; write_data = wd; read_req = rd; clr_err = clr;
        was_full = (q.size() == 16);
        was_emp  = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_ov = 0; m_un = 0; m_rv0 = 0; m_rd0 = 8'h00;
        end else begin
            m_rv0 = rd && !was_emp;
            if (m_rv0) m_rd0 = q.pop_front();
            if (wr && !was_full) q.push_back(wd);
            m_ov = (m_ov && !clr) || (wr && was_full);
            m_un = (m_un && !clr) || (rd && was_emp);
        end
        @(posedge clk);
        #1;
        $display("cyc rst=%0b wr=%0b wd=%02h rd=%0b clr=%0b -> count=%0d rv=%0b rdata=%02h fwft_rdata=%02h ov=%0b un=%0b",
                 rst, wr, wd, rd, clr, cnt0, rv0, rdata0, rdata1, ov0, un0);
        compare_all();
    endtask

    typedef struct {
        bit       wr;
        bit [7:0] wd;
        bit       rd;
        int       cnt;
        bit       full, emp, afull, aemp, ov, un;
        bit       chk_rd;
        bit [7:0] rdata;
    } vec_t;

    vec_t tbl[34];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Tests 1 and 2: fill with 0x00..0x0F plus one extra write, then drain plus one extra read.
        for (int i = 0; i < 17; i++) begin
            tbl[i].wr = 1; tbl[i].wd = i[7:0]; tbl[i].rd = 0;
            tbl[i].cnt = (i < 16) ? i + 1 : 16;
            tbl[i].ov = (i == 16); tbl[i].un = 0;
            tbl[i].chk_rd = 0; tbl[i].rdata = 8'h00;
        end
        for (int j = 0; j < 17; j++) begin
            tbl[17+j].wr = 0; tbl[17+j].wd = 8'h00; tbl[17+j].rd = 1;
            tbl[17+j].cnt = (j < 16) ? 15 - j : 0;
            tbl[17+j].ov = 1; tbl[17+j].un = (j == 16);
            tbl[17+j].chk_rd = (j < 16); tbl[17+j].rdata = j[7:0];
        end
        for (int k = 0; k < 34; k++) begin
            tbl[k].full  = (tbl[k].cnt == 16);
            tbl[k].emp   = (tbl[k].cnt == 0);
            tbl[k].afull = (tbl[k].cnt >= 14);
            tbl[k].aemp  = (tbl[k].cnt <= 2);
        end

        @(posedge clk);
        #1;
        step(1, 0, 8'h00, 0, 0);
        check("reset_count", int'(cnt0), 0);
        check("reset_EMP",   int'(emp0), 1);
        check("reset_AEMP",  int'(aemp0), 1);
        check("reset_FULL",  int'(full0), 0);
        check("reset_rd_valid", int'(rv0), 0);

        for (int k = 0; k < 34; k++) begin
            step(0, tbl[k].wr, tbl[k].wd, tbl[k].rd, 0);
            check("tbl_count", int'(cnt0),  tbl[k].cnt);
            check("tbl_FULL",  int'(full0), int'(tbl[k].full));
            check("tbl_EMP",   int'(emp0),  int'(tbl[k].emp));
            check("tbl_AFULL", int'(afull0), int'(tbl[k].afull));
            check("tbl_AEMP",  int'(aemp0), int'(tbl[k].aemp));
            check("tbl_overflow",  int'(ov0), int'(tbl[k].ov));
            check("tbl_underflow", int'(un0), int'(tbl[k].un));
            if (tbl[k].chk_rd) begin
                check("tbl_rd_valid",  int'(rv0),    1);
                check("tbl_read_data", int'(rdata0), int'(tbl[k].rdata));
            end
        end

        // Test 3: prime three words, then stream through both pointer wraps.
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 8'(8'h80 + i), 1, 0);
            check("stream_count", int'(cnt0), 3);
            check("stream_data",  int'(rdata0), (i < 3) ? 8'h40 + i : 8'h80 + i - 3);
        end

        // Test 6: reset with count=9 and overflow set, then clr_err vs a new overflow.
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
        check("pre_reset_count", int'(cnt0), 9);
        check("pre_reset_overflow", int'(ov0), 1);
        step(1, 0, 8'h00, 0, 0);
        check("rst_count", int'(cnt0), 0);
        check("rst_EMP", int'(emp0), 1);
        check("rst_overflow", int'(ov0), 0);
        check("rst_read_data", int'(rdata0), 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i * 3), 0, 0);
        step(0, 1, 8'hEE, 0, 1);
        check("clr_vs_set_overflow", int'(ov0), 1);

        // Test 4: simultaneous read/write at full and at empty.
        step(0, 0, 8'h00, 0, 1);
        check("clr_overflow", int'(ov0), 0);
        step(0, 1, 8'h77, 1, 0);
        check("full_rw_count", int'(cnt0), 15);
        check("full_rw_FULL", int'(full0), 0);
        check("full_rw_overflow", int'(ov0), 1);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h5A, 1, 0);
        check("empty_rw_count", int'(cnt0), 1);
        check("empty_rw_EMP", int'(emp0), 0);
        check("empty_rw_underflow", int'(un0), 1);
        check("empty_rw_fwft_data", int'(rdata1), 8'h5A);

        // Test 5: FWFT word appears without a read request.
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'hA5, 0, 0);
        check("fwft_show_data", int'(rdata1), 8'hA5);
        check("fwft_show_valid", int'(rv1), 1);
        step(0, 0, 8'h00, 1, 0);
        check("fwft_pop_EMP", int'(emp1), 1);
        check("fwft_pop_valid", int'(rv1), 0);

        // Randomised traffic against the model, with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            bit wr, rd, clr, rst;
            wr  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 65 : 35));
            rd  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 35 : 65));
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step(rst, wr, 8'($urandom), rd, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
